pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the CPU datapath. It replaces the fixed, always-enabled inter-stage latch with a valid/ready stage that carries N data lanes plus a control sideband. The stage supports back-pressure (stall), flush (bubble insertion) and sticky halt capture. It is instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) with per-site parameters.

---
 rtl/cpu_pipe_pkg.sv | 33 +++
 rtl/pipe_skid_entry.sv | 26 ++
 rtl/pipe_stage_reg.sv | 98 +++++++++
 tb/tb_pipe_stage_reg.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline constants, per-site control bit positions and the MEM/WB control struct.
package cpu_pipe_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_ADDR_W = 4;

  // MEM/WB site: lanes are {memory data, ALU result}, ctrl is {DstReg, HLT, RegWrite, MemToReg}
  localparam int unsigned MEMWB_NLANES = 2;
  localparam int unsigned MEMWB_CTRL_W = 7;
  localparam int unsigned MEMTOREG_BIT = 0;
  localparam int unsigned REGWRITE_BIT = 1;
  localparam int unsigned HLT_BIT      = 2;
  localparam int unsigned DSTREG_LSB   = 3;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst_reg;
    logic                  hlt;
    logic                  reg_write;
    logic                  mem_to_reg;
  } memwb_ctrl_t;

  function automatic memwb_ctrl_t memwb_ctrl(input logic [REG_ADDR_W-1:0] dst,
                                             input logic hlt, input logic reg_write,
                                             input logic mem_to_reg);
    memwb_ctrl_t c;
    c.dst_reg    = dst;
    c.hlt        = hlt;
    c.reg_write  = reg_write;
    c.mem_to_reg = mem_to_reg;
    return c;
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// Single valid + payload holding register; clear has priority over load.
module pipe_skid_entry #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush, sticky halt and masked control sideband.
// Optional second (skid) entry with registered in_ready: define PIPE_STAGE_SKID_EN.
module pipe_stage_reg #(
  parameter int unsigned DATA_W  = cpu_pipe_pkg::DATA_W,
  parameter int unsigned NLANES  = cpu_pipe_pkg::MEMWB_NLANES,
  parameter int unsigned CTRL_W  = cpu_pipe_pkg::MEMWB_CTRL_W,
  parameter int unsigned HLT_BIT = cpu_pipe_pkg::HLT_BIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NLANES*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]        in_ctrl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NLANES*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]        out_ctrl,
  input  logic                     flush,
  output logic                     halted
);

  localparam int unsigned BUS_W = NLANES * DATA_W;
  localparam int unsigned PAY_W = CTRL_W + BUS_W;

  logic             m_valid;
  logic [PAY_W-1:0] m_payload;
  logic [PAY_W-1:0] m_d;
  logic [PAY_W-1:0] in_payload;
  logic             m_load;
  logic             m_clr;
  logic             in_fire;
  logic             out_fire;
  logic             accept_ok;

  assign in_payload = {in_ctrl, in_data};
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = m_valid & out_ready;
  assign accept_ok  = ~rst & ~flush & ~halted;

`ifdef PIPE_STAGE_SKID_EN
  logic             s_valid;
  logic [PAY_W-1:0] s_payload;
  logic             s_load;
  logic             s_clr;
  logic             m_free;

  // in_ready depends only on flops plus rst/flush, never on out_ready
  assign in_ready = accept_ok & ~s_valid;
  assign m_free   = ~m_valid | out_ready;

  // Main refills from skid first so ordering is preserved
  assign m_load = ~flush & m_free & (s_valid | in_fire);
  assign m_d    = s_valid ? s_payload : in_payload;
  assign m_clr  = flush | (m_free & ~m_load);
  assign s_load = in_fire & ~m_free;
  assign s_clr  = flush | (s_valid & m_free);

  pipe_skid_entry #(.W(PAY_W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clr   (s_clr),
    .load  (s_load),
    .d     (in_payload),
    .valid (s_valid),
    .q     (s_payload)
  );
`else
  assign in_ready = accept_ok & (~m_valid | out_ready);
  assign m_load   = in_fire;
  assign m_d      = in_payload;
  assign m_clr    = flush | (out_fire & ~in_fire);
`endif

  pipe_skid_entry #(.W(PAY_W)) u_main (
    .clk   (clk),
    .rst   (rst),
    .clr   (m_clr),
    .load  (m_load),
    .d     (m_d),
    .valid (m_valid),
    .q     (m_payload)
  );

  assign out_valid = m_valid;
  assign out_data  = m_payload[BUS_W-1:0];
  // A bubble must never present RegWrite/MemToReg/HLT downstream
  assign out_ctrl  = m_valid ? m_payload[PAY_W-1:BUS_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (out_fire && !flush && m_payload[BUS_W + HLT_BIT]) begin
      halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random traffic against a queue model.
// Build with PIPE_STAGE_SKID_EN defined to check the two-entry variant.
module tb_pipe_stage_reg;
  import cpu_pipe_pkg::*;

  localparam int unsigned DW = DATA_W;
  localparam int unsigned NL = MEMWB_NLANES;
  localparam int unsigned CW = MEMWB_CTRL_W;
  localparam int unsigned HB = HLT_BIT;
  localparam int unsigned BW = NL * DW;
`ifdef PIPE_STAGE_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          flush;
  logic          halted;

  pipe_stage_reg #(.DATA_W(DW), .NLANES(NL), .CTRL_W(CW), .HLT_BIT(HB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .flush     (flush),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] data;
    logic [CW-1:0] ctrl;
  } word_t;

  word_t       q[$];
  logic [15:0] seen[$];
  bit          m_halted;
  int          tests;
  int          fails;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Acceptance rule from the current inputs and the model's occupancy
  function automatic bit exp_in_ready();
    if (rst || flush || m_halted) return 1'b0;
    if (CAP == 1) return (q.size() == 0) || out_ready;
    return q.size() < CAP;
  endfunction

  task automatic step();
    bit    ir;
    bit    ofire;
    word_t w;
    #1;
    ir = exp_in_ready();
    check("in_ready", 64'(in_ready), 64'(ir));
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_halted = 1'b0;
    end else begin
      ofire = (q.size() > 0) && out_ready;
      if (ofire) seen.push_back(q[0].data[15:0]);
      if (flush) begin
        q.delete();
      end else begin
        if (ofire) begin
          w = q.pop_front();
          if (w.ctrl[HB]) m_halted = 1'b1;
        end
        if (in_valid && ir) begin
          w.data = in_data;
          w.ctrl = in_ctrl;
          q.push_back(w);
        end
      end
    end
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check("out_data", 64'(out_data), 64'(q[0].data));
      check("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
    end else begin
      check("out_ctrl_bubble", 64'(out_ctrl), 64'd0);
    end
    check("halted", 64'(halted), 64'(m_halted));
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    rst       = 1'b0;
    in_ctrl   = '0;
  endtask

  initial begin
    int          idx;
    bit          acc;
    logic [15:0] lane0;
    memwb_ctrl_t hc;

    tests = 0;
    fails = 0;
    m_halted = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_data = '0; in_ctrl = '0;

    // reset state
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    idle();

    // back-to-back stream of 8 words
    seen.delete();
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = {16'($urandom), 16'(i)};
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("stream_count", 64'(seen.size()), 64'd8);
    for (int i = 0; i < 8 && i < seen.size(); i++) check("stream_order", 64'(seen[i]), 64'(i + 1));

    // 3-cycle stall mid-stream
    seen.delete();
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = idx < 6;
      in_data   = {16'hA5A5, 16'(16'h0011 + idx)};
      acc = in_valid && exp_in_ready();
      step();
      if (acc) idx++;
    end
    idle();
    step();
    check("stall_count", 64'(seen.size()), 64'd6);
    for (int i = 0; i < 6 && i < seen.size(); i++) check("stall_order", 64'(seen[i]), 64'(16'h0011 + i));

    // flush with a RegWrite word held; flush-cycle input must vanish
    seen.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {16'h0000, 16'h0042};
    in_ctrl   = memwb_ctrl(4'h5, 1'b0, 1'b1, 1'b0);
    step();
    flush    = 1'b1;
    in_data  = {16'h0000, 16'hBEEF};
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_ctrl", 64'(out_ctrl), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    foreach (seen[i]) check("flush_no_beef", 64'(seen[i] == 16'hBEEF), 64'd0);
    check("flush_nothing_out", 64'(seen.size()), 64'd0);

    // halt capture, lockout, flush-immune, rst clears
    seen.delete();
    hc = memwb_ctrl(4'h0, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_ctrl  = hc;
    in_data  = {16'h0000, 16'h000A};
    step();
    in_valid = 1'b0;
    in_ctrl  = '0;
    step();
    check("halt_set", 64'(halted), 64'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = {16'h0000, 16'(16'h000B + i / 2)};
      step();
      check("halt_no_out", 64'(out_valid), 64'd0);
    end
    check("halt_only_one_out", 64'(seen.size()), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("halt_survives_flush", 64'(halted), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check("halt_cleared_by_rst", 64'(halted), 64'd0);
    step();

    // reset with words held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = {16'h1234, 16'(16'h0100 + i)};
      step();
    end
    check("held_before_rst", 64'(q.size()), 64'(CAP));
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_halted", 64'(halted), 64'd0);
    step();

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 49) == 0;
      rst       = ($urandom_range(0, 499) == 0) || (m_halted && $urandom_range(0, 19) == 0);
      in_data   = BW'($urandom);
      in_ctrl   = CW'($urandom);
      in_ctrl[HB] = $urandom_range(0, 149) == 0;
      step();
    end
    idle();
    for (int i = 0; i < 3; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
